frv_axi_sram_responder: RTL and testbench

AXI4-Lite slave that serves the AXI master side of the CPU wrapper's instruction and data ports from a single-port synchronous SRAM. It captures the AW, W and AR channels independently into one-entry holding slots. It arbitrates one SRAM access at a time and returns B and R responses, with SLVERR for out-of-range addresses. It is used as the memory model and FPGA on-chip RAM behind imem/dmem.

---
 rtl/frv_axi_pkg.sv | 38 +++
 rtl/frv_axi_sram_responder_if.sv | 63 ++++++
 rtl/frv_axi_slot.sv | 47 ++++
 rtl/frv_axi_sram_responder.sv | 217 +++++++++++++++++++++
 tb/tb_frv_axi_sram_responder.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frv_axi_pkg.sv
// ---------------------------------------------------------------------------
// frv_axi_pkg
// Shared definitions for the AXI4-Lite SRAM responder:
//   - AXI response codes (OKAY / SLVERR)
//   - responder FSM state encoding
//   - address-window decode helper
// ---------------------------------------------------------------------------
package frv_axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
    localparam logic [1:0] ST_RD_WAIT_ENC = 2'd1;
    localparam logic [1:0] ST_RD_RSP_ENC  = 2'd2;
    localparam logic [1:0] ST_WR_RSP_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = ST_IDLE_ENC,
        ST_RD_WAIT = ST_RD_WAIT_ENC,
        ST_RD_RSP  = ST_RD_RSP_ENC,
        ST_WR_RSP  = ST_WR_RSP_ENC
    } state_t;

    // True when base <= addr < base + win_bytes. The subtraction is done on
    // 33 bits so an address below the base shows up as a set borrow bit
    // instead of wrapping into the window.
    function automatic logic addr_in_window(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [32:0] win_bytes
    );
        logic [32:0] off;
        off = {1'b0, addr} - {1'b0, base};
        return (off[32] == 1'b0) && (off < win_bytes);
    endfunction

endpackage

// File: rtl/frv_axi_sram_responder_if.sv
// ---------------------------------------------------------------------------
// frv_axi_sram_responder_if
// AXI4-Lite bus bundle between the CPU wrapper (master) and the SRAM
// responder (slave).
//   AW: awvalid/awready/awaddr/awprot
//   W : wvalid/wready/wdata/wstrb
//   B : bvalid/bready/bresp
//   AR: arvalid/arready/araddr/arprot
//   R : rvalid/rready/rdata/rresp
// ---------------------------------------------------------------------------
interface frv_axi_sram_responder_if;

    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [2:0]  awprot;

    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;

    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;

    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [2:0]  arprot;

    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport slave (
        input  awvalid, awaddr, awprot,
        output awready,
        input  wvalid, wdata, wstrb,
        output wready,
        output bvalid, bresp,
        input  bready,
        input  arvalid, araddr, arprot,
        output arready,
        output rvalid, rdata, rresp,
        input  rready
    );

    modport master (
        output awvalid, awaddr, awprot,
        input  awready,
        output wvalid, wdata, wstrb,
        input  wready,
        input  bvalid, bresp,
        output bready,
        output arvalid, araddr, arprot,
        input  arready,
        input  rvalid, rdata, rresp,
        output rready
    );

endinterface

// File: rtl/frv_axi_slot.sv
// ---------------------------------------------------------------------------
// frv_axi_slot
// One-entry valid/ready holding register for a single AXI request channel.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : upstream valid
//   in_ready   : upstream ready (high while the slot is empty)
//   in_data    : payload captured on handshake
//   clear      : consumer has taken the held payload
//   held       : slot holds a payload
//   data       : held payload
// ---------------------------------------------------------------------------
module frv_axi_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clear,
    output logic             held,
    output logic [WIDTH-1:0] data
);

    logic             held_r;
    logic [WIDTH-1:0] data_r;

    // Slot occupancy and payload capture. Clear is only raised while the
    // slot is full, so it never races a new handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_r <= 1'b0;
            data_r <= {WIDTH{1'b0}};
        end else if (clear) begin
            held_r <= 1'b0;
        end else if (in_valid && !held_r) begin
            held_r <= 1'b1;
            data_r <= in_data;
        end
    end

    assign in_ready = !held_r;
    assign held     = held_r;
    assign data     = data_r;

endmodule

// File: rtl/frv_axi_sram_responder.sv
// ---------------------------------------------------------------------------
// frv_axi_sram_responder
// AXI4-Lite slave serving a single-port synchronous SRAM. AW, W and AR are
// captured into independent one-entry slots; one SRAM access is performed at
// a time and answered on B or R. Addresses outside the SRAM window get
// SLVERR without touching the SRAM.
// Ports:
//   g_clk, g_reset : clock, asynchronous active-high reset
//   axi            : AXI4-Lite slave bundle
//   sram_cen       : SRAM access enable (one cycle per in-range access)
//   sram_wen       : SRAM write enable, qualified by sram_cen
//   sram_addr      : SRAM word address
//   sram_wstrb     : SRAM byte-write enables
//   sram_wdata     : SRAM write data
//   sram_rdata     : SRAM read data, valid the cycle after a read
// ---------------------------------------------------------------------------
module frv_axi_sram_responder
    import frv_axi_pkg::*;
#(
    parameter logic [31:0] MEM_BASE    = 32'h8000_0000,
    parameter int          MEM_WORDS   = 1024,
    parameter int          ADDR_W      = $clog2(MEM_WORDS),
    parameter bit          WR_PRIORITY = 1'b1
) (
    input  logic                   g_clk,
    input  logic                   g_reset,
    frv_axi_sram_responder_if.slave axi,
    output logic                   sram_cen,
    output logic                   sram_wen,
    output logic [ADDR_W-1:0]      sram_addr,
    output logic [3:0]             sram_wstrb,
    output logic [31:0]            sram_wdata,
    input  logic [31:0]            sram_rdata
);

    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;

    // Slot outputs
    logic        aw_held_s;
    logic        w_held_s;
    logic        ar_held_s;
    logic [31:0] aw_addr_s;
    logic [35:0] w_pay_s;
    logic [31:0] ar_addr_s;
    logic [31:0] w_data_s;
    logic [3:0]  w_strb_s;

    // Decode
    logic [31:0]       aw_off_s;
    logic [31:0]       ar_off_s;
    logic [ADDR_W-1:0] aw_idx_s;
    logic [ADDR_W-1:0] ar_idx_s;
    logic              aw_in_s;
    logic              ar_in_s;
    logic              wr_go_s;
    logic              rd_go_s;
    logic              unused_s;

    // FSM and response registers
    state_t      state_r;
    logic        bvalid_r;
    logic [1:0]  bresp_r;
    logic        rvalid_r;
    logic [1:0]  rresp_r;
    logic [31:0] rdata_r;

    frv_axi_slot #(.WIDTH(32)) u_aw_slot (
        .clk      (g_clk),
        .rst      (g_reset),
        .in_valid (axi.awvalid),
        .in_ready (axi.awready),
        .in_data  (axi.awaddr),
        .clear    (wr_go_s),
        .held     (aw_held_s),
        .data     (aw_addr_s)
    );

    frv_axi_slot #(.WIDTH(36)) u_w_slot (
        .clk      (g_clk),
        .rst      (g_reset),
        .in_valid (axi.wvalid),
        .in_ready (axi.wready),
        .in_data  ({axi.wstrb, axi.wdata}),
        .clear    (wr_go_s),
        .held     (w_held_s),
        .data     (w_pay_s)
    );

    frv_axi_slot #(.WIDTH(32)) u_ar_slot (
        .clk      (g_clk),
        .rst      (g_reset),
        .in_valid (axi.arvalid),
        .in_ready (axi.arready),
        .in_data  (axi.araddr),
        .clear    (rd_go_s),
        .held     (ar_held_s),
        .data     (ar_addr_s)
    );

    assign w_data_s = w_pay_s[31:0];
    assign w_strb_s = w_pay_s[35:32];

    // Byte offsets into the window; only the word-index bits are used, the
    // range check is done separately on the full address.
    assign aw_off_s = aw_addr_s - MEM_BASE;
    assign ar_off_s = ar_addr_s - MEM_BASE;
    assign aw_idx_s = aw_off_s[ADDR_W+1:2];
    assign ar_idx_s = ar_off_s[ADDR_W+1:2];
    assign aw_in_s  = addr_in_window(aw_addr_s, MEM_BASE, MEM_BYTES);
    assign ar_in_s  = addr_in_window(ar_addr_s, MEM_BASE, MEM_BYTES);

    // Protection bits and the out-of-window offset bits carry no meaning here.
    assign unused_s = &{1'b0, axi.awprot, axi.arprot,
                        aw_off_s[31:ADDR_W+2], aw_off_s[1:0],
                        ar_off_s[31:ADDR_W+2], ar_off_s[1:0]};

    // Arbitration: only in IDLE, a complete write (AW and W) competes with a
    // held read; WR_PRIORITY breaks the tie.
    always_comb begin
        wr_go_s = 1'b0;
        rd_go_s = 1'b0;
        if (state_r == ST_IDLE) begin
            wr_go_s = aw_held_s && w_held_s && (WR_PRIORITY || !ar_held_s);
            rd_go_s = ar_held_s && !wr_go_s;
        end else begin
            wr_go_s = 1'b0;
            rd_go_s = 1'b0;
        end
    end

    // SRAM command: decoded from registered state and slot contents so the
    // access happens in the IDLE cycle that accepts the request.
    always_comb begin
        sram_cen   = 1'b0;
        sram_wen   = 1'b0;
        sram_addr  = {ADDR_W{1'b0}};
        sram_wstrb = 4'b0000;
        sram_wdata = 32'h0000_0000;
        if (wr_go_s && aw_in_s) begin
            sram_cen   = 1'b1;
            sram_wen   = 1'b1;
            sram_addr  = aw_idx_s;
            sram_wstrb = w_strb_s;
            sram_wdata = w_data_s;
        end else if (rd_go_s && ar_in_s) begin
            sram_cen   = 1'b1;
            sram_wen   = 1'b0;
            sram_addr  = ar_idx_s;
        end else begin
            sram_cen   = 1'b0;
            sram_wen   = 1'b0;
        end
    end

    // Transaction FSM with registered B/R response outputs.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state_r  <= ST_IDLE;
            bvalid_r <= 1'b0;
            bresp_r  <= AXI_RESP_OKAY;
            rvalid_r <= 1'b0;
            rresp_r  <= AXI_RESP_OKAY;
            rdata_r  <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (wr_go_s) begin
                        bresp_r  <= aw_in_s ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                        bvalid_r <= 1'b1;
                        state_r  <= ST_WR_RSP;
                    end else if (rd_go_s) begin
                        if (ar_in_s) begin
                            state_r <= ST_RD_WAIT;
                        end else begin
                            rdata_r  <= 32'h0000_0000;
                            rresp_r  <= AXI_RESP_SLVERR;
                            rvalid_r <= 1'b1;
                            state_r  <= ST_RD_RSP;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RD_WAIT: begin
                    rdata_r  <= sram_rdata;
                    rresp_r  <= AXI_RESP_OKAY;
                    rvalid_r <= 1'b1;
                    state_r  <= ST_RD_RSP;
                end
                ST_RD_RSP: begin
                    if (axi.rready) begin
                        rvalid_r <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                end
                ST_WR_RSP: begin
                    if (axi.bready) begin
                        bvalid_r <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                end
                default: begin
                    bvalid_r <= 1'b0;
                    rvalid_r <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    assign axi.bvalid = bvalid_r;
    assign axi.bresp  = bresp_r;
    assign axi.rvalid = rvalid_r;
    assign axi.rresp  = rresp_r;
    assign axi.rdata  = rdata_r;

endmodule

// File: tb/tb_frv_axi_sram_responder.sv
// ---------------------------------------------------------------------------
// tb_frv_axi_sram_responder
// Directed bench: a table of single transactions with hand-computed results,
// followed by hand-written multi-cycle sequences (split AW/W arrival, write
// vs read priority for both WR_PRIORITY settings, R back-pressure with slot
// refill, reset during a read). Inputs are driven and outputs sampled on the
// falling clock edge.
// ---------------------------------------------------------------------------
module tb_frv_axi_sram_responder;

    logic g_clk;
    logic g_reset;

    int checks   = 0;
    int failures = 0;

    frv_axi_sram_responder_if ifa ();
    frv_axi_sram_responder_if ifb ();

    logic        sram_cen_a, sram_wen_a, sram_cen_b, sram_wen_b;
    logic [9:0]  sram_addr_a, sram_addr_b;
    logic [3:0]  sram_wstrb_a, sram_wstrb_b;
    logic [31:0] sram_wdata_a, sram_wdata_b;
    logic [31:0] sram_rdata_a, sram_rdata_b;

    bit [31:0] mem_a [0:1023];
    bit [31:0] mem_b [0:1023];
    int cen_cnt_a = 0;
    int cen_cnt_b = 0;

    frv_axi_sram_responder #(.WR_PRIORITY(1'b1)) u_dut_a (
        .g_clk      (g_clk),
        .g_reset    (g_reset),
        .axi        (ifa),
        .sram_cen   (sram_cen_a),
        .sram_wen   (sram_wen_a),
        .sram_addr  (sram_addr_a),
        .sram_wstrb (sram_wstrb_a),
        .sram_wdata (sram_wdata_a),
        .sram_rdata (sram_rdata_a)
    );

    frv_axi_sram_responder #(.WR_PRIORITY(1'b0)) u_dut_b (
        .g_clk      (g_clk),
        .g_reset    (g_reset),
        .axi        (ifb),
        .sram_cen   (sram_cen_b),
        .sram_wen   (sram_wen_b),
        .sram_addr  (sram_addr_b),
        .sram_wstrb (sram_wstrb_b),
        .sram_wdata (sram_wdata_b),
        .sram_rdata (sram_rdata_b)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    // SRAM model A with byte strobes and one-cycle read latency.
    always @(posedge g_clk) begin
        if (sram_cen_a) begin
            cen_cnt_a <= cen_cnt_a + 1;
            if (sram_wen_a) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wstrb_a[b]) mem_a[sram_addr_a][8*b +: 8] <= sram_wdata_a[8*b +: 8];
            end else begin
                sram_rdata_a <= mem_a[sram_addr_a];
            end
        end
    end

    // SRAM model B.
    always @(posedge g_clk) begin
        if (sram_cen_b) begin
            cen_cnt_b <= cen_cnt_b + 1;
            if (sram_wen_b) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wstrb_b[b]) mem_b[sram_addr_b][8*b +: 8] <= sram_wdata_b[8*b +: 8];
            end else begin
                sram_rdata_b <= mem_b[sram_addr_b];
            end
        end
    end

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          lat;
        int          cen;
    } vec_t;

    vec_t vecs [14];

    task automatic step();
        @(negedge g_clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Wait (bounded) for B or R valid on DUT A; lat = falling edges waited.
    task automatic wait_a(input bit is_wr, input string nm, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        for (int k = 0; k < 20; k++) begin
            if ((is_wr ? ifa.bvalid : ifa.rvalid) === 1'b1) begin
                seen = 1'b1;
                break;
            end
            step();
            lat++;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_timeout: got no valid expected valid within 20 cycles", nm);
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int c0;
        int lat;
        c0 = cen_cnt_a;
        if (v.is_wr) begin
            ifa.awaddr = v.addr; ifa.awvalid = 1'b1;
            ifa.wdata  = v.data; ifa.wstrb   = v.strb; ifa.wvalid = 1'b1;
        end else begin
            ifa.araddr = v.addr; ifa.arvalid = 1'b1;
        end
        step();
        ifa.awvalid = 1'b0; ifa.wvalid = 1'b0; ifa.arvalid = 1'b0;
        wait_a(v.is_wr, nm, lat);
        chk({nm, "_latency"}, 32'(lat + 1), 32'(v.lat));
        if (v.is_wr) begin
            chk({nm, "_bresp"}, {30'd0, ifa.bresp}, {30'd0, v.resp});
        end else begin
            chk({nm, "_rresp"}, {30'd0, ifa.rresp}, {30'd0, v.resp});
            chk({nm, "_rdata"}, ifa.rdata, v.rdata);
        end
        chk({nm, "_cen_pulses"}, 32'(cen_cnt_a - c0), 32'(v.cen));
        if (v.is_wr) ifa.bready = 1'b1; else ifa.rready = 1'b1;
        step();
        ifa.bready = 1'b0; ifa.rready = 1'b0;
        chk({nm, "_valid_drop"}, {31'd0, (v.is_wr ? ifa.bvalid : ifa.rvalid)}, 32'd0);
    endtask

    initial begin
        int lat;
        int c0;
        int rv_seen;
        bit seen_a, seen_b;
        vec_t rd;

        g_reset = 1'b1;
        ifa.awvalid = 1'b0; ifa.awaddr = 32'd0; ifa.awprot = 3'd0;
        ifa.wvalid = 1'b0;  ifa.wdata = 32'd0;  ifa.wstrb = 4'd0;
        ifa.bready = 1'b0;  ifa.arvalid = 1'b0; ifa.araddr = 32'd0;
        ifa.arprot = 3'd0;  ifa.rready = 1'b0;
        ifb.awvalid = 1'b0; ifb.awaddr = 32'd0; ifb.awprot = 3'd0;
        ifb.wvalid = 1'b0;  ifb.wdata = 32'd0;  ifb.wstrb = 4'd0;
        ifb.bready = 1'b0;  ifb.arvalid = 1'b0; ifb.araddr = 32'd0;
        ifb.arprot = 3'd0;  ifb.rready = 1'b0;

        //          wr    addr          data           strb   resp   rdata          lat cen
        vecs[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0,         2, 1};
        vecs[1]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF, 3, 1};
        vecs[2]  = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 2'b10, 32'h0,         2, 0};
        vecs[3]  = '{1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, 2'b00, 32'h0,         2, 1};
        vecs[4]  = '{1'b1, 32'h8000_0FFC, 32'hCAFE_F00D, 4'hF, 2'b00, 32'h0,         2, 1};
        vecs[5]  = '{1'b0, 32'h8000_0FFC, 32'h0,         4'h0, 2'b00, 32'hCAFE_F00D, 3, 1};
        vecs[6]  = '{1'b1, 32'h8000_1000, 32'h5555_5555, 4'hF, 2'b10, 32'h0,         2, 0};
        vecs[7]  = '{1'b0, 32'h8000_1000, 32'h0,         4'h0, 2'b10, 32'h0,         2, 0};
        vecs[8]  = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 2'b10, 32'h0,         2, 0};
        vecs[9]  = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 2'b00, 32'h0,         3, 1};
        vecs[10] = '{1'b1, 32'h8000_0FFD, 32'h1234_5678, 4'hC, 2'b00, 32'h0,         2, 1};
        vecs[11] = '{1'b0, 32'h8000_0FFE, 32'h0,         4'h0, 2'b00, 32'h1234_F00D, 3, 1};
        vecs[12] = '{1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 2'b00, 32'h0,         2, 1};
        vecs[13] = '{1'b0, 32'h8000_0013, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF, 3, 1};

        // Reset state
        step(); step();
        chk("rst_awready", {31'd0, ifa.awready}, 32'd1);
        chk("rst_wready",  {31'd0, ifa.wready},  32'd1);
        chk("rst_arready", {31'd0, ifa.arready}, 32'd1);
        chk("rst_bvalid",  {31'd0, ifa.bvalid},  32'd0);
        chk("rst_rvalid",  {31'd0, ifa.rvalid},  32'd0);
        chk("rst_bresp",   {30'd0, ifa.bresp},   32'd0);
        chk("rst_rresp",   {30'd0, ifa.rresp},   32'd0);
        chk("rst_rdata",   ifa.rdata,            32'd0);
        chk("rst_sram_cen", {31'd0, sram_cen_a}, 32'd0);
        chk("rst_sram_wen", {31'd0, sram_wen_a}, 32'd0);
        g_reset = 1'b0;
        step();

        // Table of single transactions
        for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // W arrives three cycles before AW, partial strobe over 0x11223344
        c0 = cen_cnt_a;
        ifa.wdata = 32'h0000_AB00; ifa.wstrb = 4'b0010; ifa.wvalid = 1'b1;
        step();
        ifa.wvalid = 1'b0;
        chk("split_wready_held", {31'd0, ifa.wready}, 32'd0);
        step(); step();
        chk("split_no_early_access", 32'(cen_cnt_a - c0), 32'd0);
        ifa.awaddr = 32'h8000_0020; ifa.awvalid = 1'b1;
        step();
        ifa.awvalid = 1'b0;
        chk("split_sram_cen",   {31'd0, sram_cen_a}, 32'd1);
        chk("split_sram_wen",   {31'd0, sram_wen_a}, 32'd1);
        chk("split_sram_addr",  {22'd0, sram_addr_a}, 32'd8);
        chk("split_sram_wstrb", {28'd0, sram_wstrb_a}, 32'h2);
        chk("split_sram_wdata", sram_wdata_a, 32'h0000_AB00);
        step();
        chk("split_bvalid", {31'd0, ifa.bvalid}, 32'd1);
        chk("split_bresp",  {30'd0, ifa.bresp},  32'd0);
        ifa.bready = 1'b1;
        step();
        ifa.bready = 1'b0;
        chk("split_cen_pulses", 32'(cen_cnt_a - c0), 32'd1);
        chk("split_mem_word", mem_a[8], 32'h1122_AB44);
        rd = '{1'b0, 32'h8000_0020, 32'h0, 4'h0, 2'b00, 32'h1122_AB44, 3, 1};
        run_vec(rd, "split_readback");

        // Write and read pending together: A (write first) vs B (read first)
        ifa.awaddr = 32'h8000_0040; ifa.wdata = 32'hA5A5_A5A5; ifa.wstrb = 4'hF;
        ifa.araddr = 32'h8000_0040;
        ifb.awaddr = 32'h8000_0040; ifb.wdata = 32'hA5A5_A5A5; ifb.wstrb = 4'hF;
        ifb.araddr = 32'h8000_0040;
        ifa.awvalid = 1'b1; ifa.wvalid = 1'b1; ifa.arvalid = 1'b1;
        ifb.awvalid = 1'b1; ifb.wvalid = 1'b1; ifb.arvalid = 1'b1;
        step();
        ifa.awvalid = 1'b0; ifa.wvalid = 1'b0; ifa.arvalid = 1'b0;
        ifb.awvalid = 1'b0; ifb.wvalid = 1'b0; ifb.arvalid = 1'b0;
        chk("prio_a_first_is_write", {31'd0, sram_wen_a}, 32'd1);
        chk("prio_b_first_is_read",  {30'd0, sram_cen_b, sram_wen_b}, 32'b10);
        step(); step();
        chk("prio_a_bvalid",  {31'd0, ifa.bvalid},  32'd1);
        chk("prio_a_rvalid",  {31'd0, ifa.rvalid},  32'd0);
        chk("prio_a_arready", {31'd0, ifa.arready}, 32'd0);
        chk("prio_b_rvalid",  {31'd0, ifb.rvalid},  32'd1);
        chk("prio_b_bvalid",  {31'd0, ifb.bvalid},  32'd0);
        chk("prio_b_rdata",   ifb.rdata,            32'd0);
        chk("prio_b_awready", {31'd0, ifb.awready}, 32'd0);
        ifa.bready = 1'b1; ifb.rready = 1'b1;
        step();
        ifa.bready = 1'b0; ifb.rready = 1'b0;
        seen_a = 1'b0; seen_b = 1'b0;
        for (int k = 0; k < 20 && !(seen_a && seen_b); k++) begin
            if (ifa.rvalid === 1'b1) seen_a = 1'b1;
            if (ifb.bvalid === 1'b1) seen_b = 1'b1;
            if (!(seen_a && seen_b)) step();
        end
        chk("prio_a_second_seen", {31'd0, seen_a}, 32'd1);
        chk("prio_b_second_seen", {31'd0, seen_b}, 32'd1);
        chk("prio_a_rdata", ifa.rdata, 32'hA5A5_A5A5);
        chk("prio_a_rresp", {30'd0, ifa.rresp}, 32'd0);
        chk("prio_b_bresp", {30'd0, ifb.bresp}, 32'd0);
        chk("prio_b_mem",   mem_b[16], 32'hA5A5_A5A5);
        ifa.rready = 1'b1; ifb.bready = 1'b1;
        step();
        ifa.rready = 1'b0; ifb.bready = 1'b0;

        // R back-pressure for 5 cycles while AR and AW+W refill the slots
        ifa.araddr = 32'h8000_0010; ifa.arvalid = 1'b1;
        step();
        ifa.arvalid = 1'b0;
        wait_a(1'b0, "bp_first_read", lat);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_rvalid_hold%0d", i), {31'd0, ifa.rvalid}, 32'd1);
            chk($sformatf("bp_rdata_hold%0d", i), ifa.rdata, 32'hDEAD_BEEF);
            if (i == 0) begin
                ifa.araddr = 32'h8000_0FFC; ifa.arvalid = 1'b1;
                ifa.awaddr = 32'h8000_0024; ifa.awvalid = 1'b1;
                ifa.wdata = 32'h0BAD_CAFE; ifa.wstrb = 4'hF; ifa.wvalid = 1'b1;
            end else begin
                ifa.arvalid = 1'b0; ifa.awvalid = 1'b0; ifa.wvalid = 1'b0;
            end
            if (i == 2) begin
                chk("bp_slots_full", {29'd0, ifa.awready, ifa.wready, ifa.arready}, 32'd0);
            end
            step();
        end
        ifa.rready = 1'b1;
        step();
        ifa.rready = 1'b0;
        wait_a(1'b1, "bp_write", lat);
        chk("bp_write_before_read", {31'd0, ifa.rvalid}, 32'd0);
        chk("bp_bresp", {30'd0, ifa.bresp}, 32'd0);
        ifa.bready = 1'b1;
        step();
        ifa.bready = 1'b0;
        wait_a(1'b0, "bp_read", lat);
        chk("bp_read_rdata", ifa.rdata, 32'h1234_F00D);
        ifa.rready = 1'b1;
        step();
        ifa.rready = 1'b0;
        rd = '{1'b0, 32'h8000_0024, 32'h0, 4'h0, 2'b00, 32'h0BAD_CAFE, 3, 1};
        run_vec(rd, "bp_readback");

        // Reset while in RD_WAIT, with an AW parked in its slot
        ifa.araddr = 32'h8000_0010; ifa.arvalid = 1'b1;
        step();
        ifa.arvalid = 1'b0;
        ifa.awaddr = 32'h8000_0030; ifa.awvalid = 1'b1;
        step();
        ifa.awvalid = 1'b0;
        chk("rstmid_aw_parked", {31'd0, ifa.awready}, 32'd0);
        g_reset = 1'b1;
        #1;
        chk("rstmid_readies", {29'd0, ifa.awready, ifa.wready, ifa.arready}, 32'b111);
        chk("rstmid_rvalid", {31'd0, ifa.rvalid}, 32'd0);
        step();
        g_reset = 1'b0;
        c0 = cen_cnt_a;
        rv_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (ifa.rvalid !== 1'b0 || ifa.bvalid !== 1'b0) rv_seen++;
            step();
        end
        chk("rstmid_no_response", 32'(rv_seen), 32'd0);
        chk("rstmid_no_access", 32'(cen_cnt_a - c0), 32'd0);
        rd = '{1'b0, 32'h8000_0010, 32'h0, 4'h0, 2'b00, 32'hDEAD_BEEF, 3, 1};
        run_vec(rd, "rstmid_next_read");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
